// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared types and helpers for the push-button stopwatch control block.
//   - sw_state_t      : FSM state encoding, also driven out on StateOut
//                       (IDLE=0, RUN=1, PAUSE=2, LAP=3).
//   - KEY_SYNC_STAGES : depth of the key synchronizer chain.
//   - calc_div()      : prescaler division ratio, system clocks per count tick.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } sw_state_t;

   localparam int KEY_SYNC_STAGES = 2;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_conditioner.sv
// key_conditioner
//   Turns one asynchronous active-low push-button into a single-cycle
//   "pressed" event: synchronizer, optional debounce, falling-edge detect.
//   Holding the key produces exactly one event.
//
//   Optional feature macro: STOPWATCH_DEBOUNCE_EN
//     defined   : the synchronized level must stay at a new value for
//                 DEBOUNCE_CYCLES consecutive cycles before the debounced
//                 level follows; shorter glitches restart the count.
//     undefined : synchronizer plus edge detect only.
//
//   Ports
//     i_clk    in  system clock
//     i_rst_n  in  synchronous active-low reset
//     i_key_n  in  raw key, active-low, asynchronous to i_clk
//     o_press  out 1-cycle pulse on a (debounced) key press
module key_conditioner
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_press
);

   localparam int WARM_W = $clog2(KEY_SYNC_STAGES + 1);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("key_conditioner: DEBOUNCE_CYCLES must be at least 1");
   end

   logic [KEY_SYNC_STAGES-1:0] r_sync;
   logic                       r_prev;
   logic                       r_armed;
   logic [WARM_W-1:0]          r_warm;
   logic                       w_sync_lvl;
   logic                       w_level;

   assign w_sync_lvl = r_sync[KEY_SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[KEY_SYNC_STAGES-2:0], i_key_n};
      end
   end

`ifdef STOPWATCH_DEBOUNCE_EN
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic            r_db;
   logic [DB_W-1:0] r_db_cnt;

   // The debounced level only moves after DEBOUNCE_CYCLES consecutive cycles
   // of disagreement with the synchronized level.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_db     <= 1'b1;
         r_db_cnt <= '0;
      end else if (w_sync_lvl == r_db) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         r_db     <= w_sync_lvl;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + DB_W'(1);
      end
   end

   assign w_level = r_db;
`else
   assign w_level = w_sync_lvl;
`endif

   // The synchronizer comes out of reset as "released" regardless of the
   // real key. Events are only armed once the real key has been seen
   // released, so a key held through reset does not fire on reset release.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prev  <= 1'b1;
         r_warm  <= '0;
         r_armed <= 1'b0;
      end else begin
         r_prev <= w_level;
         if (r_warm != WARM_W'(KEY_SYNC_STAGES)) begin
            r_warm <= r_warm + WARM_W'(1);
         end
         if ((r_warm == WARM_W'(KEY_SYNC_STAGES)) && w_sync_lvl && w_level) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign o_press = r_armed & r_prev & ~w_level;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Sequences a 0000-9999 display counter as a push-button stopwatch.
//   Start/Stop and Lap/Reset keys drive a four-state FSM; a prescaler
//   produces the counter's one-cycle count-enable pulses.
//
//   Optional feature macro: STOPWATCH_DEBOUNCE_EN (key debounce, see
//   key_conditioner). Default build has no debounce.
//
//   Ports
//     Clock      in   system clock, all logic on posedge
//     Clear      in   synchronous active-low reset
//     KeyStartN  in   Start/Stop key, active-low, asynchronous
//     KeyLapN    in   Lap/Reset key, active-low, asynchronous
//     CountEn    out  1-cycle count-enable pulse to the counter
//     CountClrN  out  synchronous active-low clear to the counter
//     LapHold    out  1 = display freezes its current value
//     Running    out  1 in RUN or LAP
//     StateOut   out  encoded FSM state (IDLE=0, RUN=1, PAUSE=2, LAP=3)
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 1,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       Clock,
   input  logic       Clear,
   input  logic       KeyStartN,
   input  logic       KeyLapN,
   output logic       CountEn,
   output logic       CountClrN,
   output logic       LapHold,
   output logic       Running,
   output logic [1:0] StateOut
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   if ((DIV < 2) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_bad_div
      $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
   end

   logic w_start;
   logic w_lap;

   key_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_start (
      .i_clk   (Clock),
      .i_rst_n (Clear),
      .i_key_n (KeyStartN),
      .o_press (w_start)
   );

   key_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_lap (
      .i_clk   (Clock),
      .i_rst_n (Clear),
      .i_key_n (KeyLapN),
      .o_press (w_lap)
   );

   sw_state_t       r_state;
   sw_state_t       w_state_nxt;
   logic [PW-1:0]   r_presc;
   logic [PW-1:0]   w_presc_nxt;
   logic            r_count_en;
   logic            w_count_en_nxt;
   logic            r_clr_n;
   logic            w_clr_n_nxt;
   logic            r_lap_hold;
   logic            w_lap_hold_nxt;
   logic            r_running;
   logic            w_running_nxt;

   always_ff @(posedge Clock) begin
      if (!Clear) begin
         r_state    <= IDLE;
         r_presc    <= '0;
         r_count_en <= 1'b0;
         r_clr_n    <= 1'b0;
         r_lap_hold <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_presc    <= w_presc_nxt;
         r_count_en <= w_count_en_nxt;
         r_clr_n    <= w_clr_n_nxt;
         r_lap_hold <= w_lap_hold_nxt;
         r_running  <= w_running_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_presc_nxt    = r_presc;
      w_count_en_nxt = 1'b0;
      w_clr_n_nxt    = 1'b1;
      w_lap_hold_nxt = r_lap_hold;

      // The prescaler advances on every edge spent in RUN or LAP, including
      // the edge that leaves them, so a wrap coinciding with a Start press
      // still issues its enable and PAUSE keeps the exact fraction.
      if ((r_state == RUN) || (r_state == LAP)) begin
         if (r_presc == PW'(DIV - 1)) begin
            w_presc_nxt    = '0;
            w_count_en_nxt = 1'b1;
         end else begin
            w_presc_nxt = r_presc + PW'(1);
         end
      end

      // Start is tested first everywhere, so a simultaneous Lap is dropped.
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = RUN;
               w_presc_nxt = '0;
            end
         end
         RUN: begin
            if (w_start) begin
               w_state_nxt = PAUSE;
            end else if (w_lap) begin
               w_state_nxt    = LAP;
               w_lap_hold_nxt = 1'b1;
            end
         end
         LAP: begin
            if (w_start) begin
               w_state_nxt    = PAUSE;
               w_lap_hold_nxt = 1'b0;
            end else if (w_lap) begin
               w_state_nxt    = RUN;
               w_lap_hold_nxt = 1'b0;
            end
         end
         PAUSE: begin
            if (w_start) begin
               w_state_nxt = RUN;
            end else if (w_lap) begin
               w_state_nxt = IDLE;
               w_clr_n_nxt = 1'b0;
               w_presc_nxt = '0;
            end
         end
         default: begin
            w_state_nxt    = IDLE;
            w_presc_nxt    = '0;
            w_lap_hold_nxt = 1'b0;
         end
      endcase

      w_running_nxt = (w_state_nxt == RUN) || (w_state_nxt == LAP);
   end

   assign CountEn   = r_count_en;
   assign CountClrN = r_clr_n;
   assign LapHold   = r_lap_hold;
   assign Running   = r_running;
   assign StateOut  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

   localparam int CLK_HZ  = 10;
   localparam int TICK_HZ = 1;
   localparam int DB_CYC  = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
   localparam int LAT = 3 + DB_CYC;
`else
   localparam int LAT = 3;
`endif
   localparam int HOLD = 10;

   localparam int S_EN   = 0;
   localparam int S_CLRN = 1;
   localparam int S_HOLD = 2;
   localparam int S_RUN  = 3;
   localparam int S_ST   = 4;

   localparam int K_START = 0;
   localparam int K_LAP   = 1;
   localparam int K_BOTH  = 2;

   logic       clk;
   logic       Clear;
   logic       KeyStartN;
   logic       KeyLapN;
   logic       CountEn;
   logic       CountClrN;
   logic       LapHold;
   logic       Running;
   logic [1:0] StateOut;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         cyc;
      int         sig;
      logic [1:0] val;
      string      name;
   } exp_t;

   exp_t q[$];

   stopwatch_ctrl #(
      .CLK_HZ          (CLK_HZ),
      .TICK_HZ         (TICK_HZ),
      .DEBOUNCE_CYCLES (DB_CYC)
   ) dut (
      .Clock     (clk),
      .Clear     (Clear),
      .KeyStartN (KeyStartN),
      .KeyLapN   (KeyLapN),
      .CountEn   (CountEn),
      .CountClrN (CountClrN),
      .LapHold   (LapHold),
      .Running   (Running),
      .StateOut  (StateOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc = number of posedges so far; outputs sampled at negedge belong to it
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] sample(input int sig);
      case (sig)
         S_EN:    return {1'b0, CountEn};
         S_CLRN:  return {1'b0, CountClrN};
         S_HOLD:  return {1'b0, LapHold};
         S_RUN:   return {1'b0, Running};
         default: return StateOut;
      endcase
   endfunction

   // Scoreboard monitor: pops every expectation that is due this cycle.
   always @(negedge clk) begin
      while ((q.size() > 0) && (q[0].cyc <= cyc)) begin
         exp_t e;
         logic [1:0] act;
         e = q.pop_front();
         act = sample(e.sig);
         n_tests++;
         if (e.cyc < cyc) begin
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
         end else if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", e.name, cyc, act, e.val);
         end
      end
   end

   task automatic expect_at(input int c, input int sig, input logic [1:0] val, input string nm);
      exp_t e;
      int   i;
      e.cyc  = c;
      e.sig  = sig;
      e.val  = val;
      e.name = nm;
      i = q.size();
      while ((i > 0) && (q[i-1].cyc > c)) i--;
      q.insert(i, e);
   endtask

   // CountEn expected over [start, start+len): pulses at first, first+10, ...
   task automatic en_window(input int start, input int len, input int first, input string nm);
      for (int k = 0; k < len; k++) begin
         int c;
         logic [1:0] v;
         c = start + k;
         v = ((first >= 0) && (c >= first) && (((c - first) % 10) == 0)) ? 2'd1 : 2'd0;
         expect_at(c, S_EN, v, nm);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
      if (cyc != c) begin
         n_tests++;
         n_fail++;
         $display("FAIL schedule: reached cycle %0d, wanted %0d", cyc, c);
      end
   endtask

   // Press so that the resulting state change lands on edge e.
   task automatic press(input int which, input int e);
      wait_until(e - LAT);
      if (which != K_LAP)   KeyStartN = 1'b0;
      if (which != K_START) KeyLapN   = 1'b0;
      repeat (HOLD) @(negedge clk);
      KeyStartN = 1'b1;
      KeyLapN   = 1'b1;
   endtask

   initial begin
      int ea, t, p, r, l, l2, p2, x, s, b, qq, f;
      Clear     = 1'b0;
      KeyStartN = 1'b1;
      KeyLapN   = 1'b1;

      // reset values
      expect_at(2, S_ST,   2'd0, "rst_state");
      expect_at(2, S_EN,   2'd0, "rst_en");
      expect_at(2, S_CLRN, 2'd0, "rst_clrn");
      expect_at(2, S_HOLD, 2'd0, "rst_hold");
      expect_at(2, S_RUN,  2'd0, "rst_run");
      expect_at(3, S_CLRN, 2'd0, "rst_clrn_held");
      expect_at(4, S_CLRN, 2'd1, "clrn_release");
      @(negedge clk);
      wait_until(3);
      Clear = 1'b1;

      // Lap ignored in IDLE
      ea = 15;
      expect_at(ea,     S_ST,   2'd0, "idle_lap_state");
      expect_at(ea + 1, S_ST,   2'd0, "idle_lap_state2");
      expect_at(ea + 1, S_HOLD, 2'd0, "idle_lap_hold");
      press(K_LAP, ea);

      // IDLE -> RUN, pulses every 10 cycles
      t = ea + 20;
      expect_at(t - 1, S_ST,  2'd0, "start_pre");
      expect_at(t,     S_ST,  2'd1, "start_state");
      expect_at(t,     S_RUN, 2'd1, "start_running");
      en_window(t, 25, t + 10, "run_en");
      press(K_START, t);

      // RUN -> PAUSE at prescaler 5, no pulses while paused
      p = t + 25;
      expect_at(p, S_ST,  2'd2, "pause_state");
      expect_at(p, S_RUN, 2'd0, "pause_running");
      en_window(p, 50, -1, "pause_en");
      press(K_START, p);

      // PAUSE -> RUN resumes from 5: next pulse 5 cycles later
      r = p + 50;
      expect_at(r, S_ST,  2'd1, "resume_state");
      expect_at(r, S_RUN, 2'd1, "resume_running");
      en_window(r, 20, r + 5, "resume_en");
      press(K_START, r);

      // RUN -> LAP, counting continues
      l = r + 20;
      expect_at(l - 1, S_HOLD, 2'd0, "lap_hold_pre");
      expect_at(l,     S_HOLD, 2'd1, "lap_hold");
      expect_at(l,     S_ST,   2'd3, "lap_state");
      expect_at(l,     S_RUN,  2'd1, "lap_running");
      en_window(l, 25, l + 5, "lap_en");
      press(K_LAP, l);

      // LAP -> RUN
      l2 = l + 25;
      expect_at(l2 - 1, S_HOLD, 2'd1, "unlap_hold_pre");
      expect_at(l2,     S_HOLD, 2'd0, "unlap_hold");
      expect_at(l2,     S_ST,   2'd1, "unlap_state");
      expect_at(l2,     S_EN,   2'd1, "unlap_en_wrap");
      expect_at(l2 + 10, S_EN,  2'd1, "unlap_en_next");
      press(K_LAP, l2);

      // RUN -> PAUSE, then Lap clears to IDLE
      p2 = l2 + 25;
      expect_at(p2, S_ST, 2'd2, "pause2_state");
      expect_at(p2, S_EN, 2'd0, "pause2_en");
      press(K_START, p2);

      x = p2 + 25;
      expect_at(x - 1, S_CLRN, 2'd1, "clr_pre");
      expect_at(x,     S_CLRN, 2'd0, "clr_pulse");
      expect_at(x + 1, S_CLRN, 2'd1, "clr_post");
      expect_at(x,     S_ST,   2'd0, "clr_state");
      expect_at(x,     S_RUN,  2'd0, "clr_running");
      expect_at(x,     S_EN,   2'd0, "clr_en");
      press(K_LAP, x);

      // Start after clear: prescaler starts from 0
      s = x + 25;
      expect_at(s, S_ST, 2'd1, "restart_state");
      en_window(s, 11, s + 10, "restart_en");
      press(K_START, s);

      // Both keys in the same cycle: Start wins
      b = s + 25;
      expect_at(b - 1, S_ST,   2'd1, "both_pre");
      expect_at(b,     S_ST,   2'd2, "both_state");
      expect_at(b,     S_HOLD, 2'd0, "both_hold");
      expect_at(b,     S_RUN,  2'd0, "both_running");
      expect_at(b + 5, S_ST,   2'd2, "both_state_later");
      expect_at(b + 5, S_HOLD, 2'd0, "both_hold_later");
      press(K_BOTH, b);

      // Clear mid-RUN, key held through reset
      qq = b + 25;
      expect_at(qq,      S_ST,   2'd1, "run2_state");
      expect_at(qq + 5,  S_EN,   2'd1, "run2_en");
      expect_at(qq + 10, S_ST,   2'd1, "midrst_pre");
      expect_at(qq + 11, S_ST,   2'd0, "midrst_state");
      expect_at(qq + 11, S_EN,   2'd0, "midrst_en");
      expect_at(qq + 11, S_CLRN, 2'd0, "midrst_clrn");
      expect_at(qq + 11, S_HOLD, 2'd0, "midrst_hold");
      expect_at(qq + 11, S_RUN,  2'd0, "midrst_run");
      expect_at(qq + 14, S_CLRN, 2'd1, "midrst_clrn_rel");
      expect_at(qq + 30, S_ST,   2'd0, "heldkey_state");
      expect_at(qq + 30, S_RUN,  2'd0, "heldkey_run");
      press(K_START, qq);
      wait_until(qq + 10);
      Clear = 1'b0;
      wait_until(qq + 12);
      KeyStartN = 1'b0;
      wait_until(qq + 13);
      Clear = 1'b1;
      wait_until(qq + 32);
      KeyStartN = 1'b1;

      // A fresh press after the held key works normally
      f = qq + 60;
      expect_at(f - 1, S_ST,  2'd0, "fresh_pre");
      expect_at(f,     S_ST,  2'd1, "fresh_state");
      expect_at(f,     S_RUN, 2'd1, "fresh_running");
      press(K_START, f);

`ifdef STOPWATCH_DEBOUNCE_EN
      begin
         int g;
         g = f + 20;
         wait_until(g);
         for (int k = 1; k <= 16; k++) expect_at(g + k, S_ST, 2'd1, "glitch_state");
         KeyStartN = 1'b0;
         wait_until(g + 3);
         KeyStartN = 1'b1;
         expect_at(g + 26, S_ST, 2'd1, "db_press_pre");
         expect_at(g + 27, S_ST, 2'd2, "db_press_state");
         press(K_START, g + 27);
      end
`endif

      begin
         int guard;
         guard = 0;
         while ((q.size() > 0) && (guard < 500)) begin
            @(negedge clk);
            guard++;
         end
         if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control block that sequences the 0000–9999 display counter as a push-button stopwatch.
- Conditions two active-low keys: Start/Stop and Lap/Reset.
- Generates the counter's 1-cycle count-enable pulses from the 50 MHz system clock.
- Drives the counter's active-low clear and a lap-hold signal for the display path.
- Sits between the board keys and the 4-digit counter/HEX datapath.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 1, count-enable rate; DIV = CLK_HZ/TICK_HZ, must be ≥2 and an integer.
- DEBOUNCE_CYCLES, 500000, key-stable cycles required (used only with the optional feature).

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Clear  in  1  reset, synchronous, active-low.
- KeyStartN  in  1  Start/Stop key, active-low, asynchronous to Clock.
- KeyLapN  in  1  Lap/Reset key, active-low, asynchronous to Clock.
- CountEn  out  1  one-cycle enable pulse to the counter.
- CountClrN  out  1  synchronous active-low clear to the counter.
- LapHold  out  1  1 = display latches/freezes the current value.
- Running  out  1  1 in RUN or LAP.
- StateOut  out  2  encoded FSM state, for debug and LEDs.

Behaviour:
Reset and outputs
- Clear=0 at a posedge → state IDLE, prescaler 0, CountEn 0, CountClrN 0, LapHold 0, Running 0, key pipelines reset to released (1).
- All outputs are registered. CountClrN becomes 1 on the first edge after Clear returns high.

Key conditioning
- Each key passes through a 2-flop synchronizer, then falling-edge detection.
- A press yields exactly one 1-cycle event; holding the key produces no repeats.
- Latency from key low to event: 3 cycles without debounce.

FSM (StateOut encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3)
- IDLE: Start → RUN and clear the prescaler. Lap is ignored.
- RUN: Start → PAUSE. Lap → LAP, with LapHold=1 on the same edge.
- LAP: counter keeps running while the display stays frozen. Lap → RUN, LapHold=0. Start → PAUSE, LapHold=0.
- PAUSE: Start → RUN, prescaler resumes from its held value (no lost fraction). Lap → IDLE, with CountClrN=0 for exactly one cycle and the prescaler cleared.
- Start and Lap events in the same cycle: Start wins, Lap is discarded.

Prescaler
- Counts 0..DIV-1 in RUN and LAP; holds in IDLE and PAUSE.
- Width is clog2(DIV).
- At DIV-1 it wraps to 0, and CountEn=1 on that same registered edge.
- First CountEn after IDLE→RUN arrives exactly DIV cycles after the transition edge.
- CountEn is never asserted in IDLE or PAUSE, or while CountClrN=0.
- A Start event coinciding with the wrap cycle in RUN: the transition takes effect and CountEn is still issued for that wrap.

Reset mid-operation
- Clear low in any state gives the reset values on the next edge.
- A key held through reset does not generate an event on release of Clear.

Optional Feature:
Macro: STOPWATCH_DEBOUNCE_EN
- Defined: each synchronized key must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes. Events derive from the debounced falling edge, so latency = 3 + DEBOUNCE_CYCLES cycles. Any glitch shorter than that restarts the stability count.
- Undefined: no debounce counter; synchronizer plus edge detect only; DEBOUNCE_CYCLES is unused.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [1:0] sw_state_t {IDLE, RUN, PAUSE, LAP};
  - function calc_div(CLK_HZ, TICK_HZ);
  - localparam KEY_SYNC_STAGES=2.
- Sub-module key_conditioner: synchronizer, optional debounce, falling-edge pulse. Instantiated once per key.
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan:
Run with CLK_HZ=10, TICK_HZ=1 (DIV=10), DEBOUNCE_CYCLES=4.
1. Reset, then press KeyStartN → StateOut=1, Running=1. CountEn pulses every 10 cycles, first pulse 10 cycles after the state change, each pulse 1 cycle wide.
2. RUN 25 cycles, then Start (PAUSE) for 50 cycles, then Start again → no CountEn during PAUSE. Next pulse arrives 5 cycles after resuming, because the prescaler held at 5.
3. In RUN press Lap → LapHold=1, StateOut=3, CountEn continues every 10 cycles. Press Lap again → LapHold=0, StateOut=1.
4. In PAUSE press Lap → CountClrN=0 for exactly 1 cycle, StateOut=0. Start afterwards → first CountEn 10 cycles later.
5. Assert both keys' falling edges in the same cycle while in RUN → StateOut=2 (PAUSE), LapHold stays 0. Drive Clear=0 mid-RUN → all outputs at reset values next edge.
6. With STOPWATCH_DEBOUNCE_EN: 3-cycle low glitch on KeyStartN → no event. A 10-cycle press → exactly one event, state change 7 cycles after the key falls.
